// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder.
// Holds the control FSM encoding and counter sizing.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells.
// One instance serves every chunk of the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;
  assign co   = c[CHUNK];

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: WIDTH bits summed CHUNK bits per cycle.
// Valid/ready on both sides; result flags registered on entry to DONE.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  if ((WIDTH < 1) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad
    $error("seq_adder: CHUNK must divide WIDTH");
  end

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = cnt_width(N);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cco;

  assign ca       = a_q[int'(k)*CHUNK +: CHUNK];
  assign cb       = b_q[int'(k)*CHUNK +: CHUNK];
  assign in_ready = (state == IDLE);

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (ca),
    .b  (cb),
    .ci (carry_q),
    .s  (cs),
    .co (cco)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= input1;
            b_q     <= sub ? ~input2 : input2;
            carry_q <= sub | carry_in;
            k       <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          acc[int'(k)*CHUNK +: CHUNK] <= cs;
          carry_q <= cco;
          k       <= k + KW'(1);
          if (k == KW'(N - 1)) state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the completed result
          if (!out_valid) begin
            out_valid <= 1'b1;
            sum       <= acc;
            carry_out <= carry_q;
            overflow  <= (a_q[MSB] == b_q[MSB]) &&
                         (acc[MSB] != a_q[MSB]);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench: three seq_adder instances (CHUNK 4, 16, 1)
// driven in lockstep, checked against an arithmetic reference model.
module tb_seq_adder;

  localparam int W  = 16;
  localparam int NI = 3;
  localparam int CH [NI] = '{4, 16, 1};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sb;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic         carry_in;
  logic         sub;

  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [W-1:0] sum       [NI];
  logic         carry_out [NI];
  logic         overflow  [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_adder #(
      .WIDTH (W),
      .CHUNK (CH[g])
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .input1    (input1),
      .input2    (input2),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g]),
      .carry_out (carry_out[g]),
      .overflow  (overflow[g])
    );
  end

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [chunk=%0d] got=0x%0h want=0x%0h",
               name, CH[inst], act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed values
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic s,
                       output logic [W-1:0] rs, output logic co,
                       output logic ov);
    int u;
    int sa;
    int sbv;
    int r;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (!s) begin
      u  = int'(a) + int'(b) + int'(cin);
      co = (u > 65535);
      r  = sa + sbv + int'(cin);
    end else begin
      u  = int'(a) - int'(b);
      co = (a >= b);
      r  = sa - sbv;
    end
    rs = u[W-1:0];
    ov = (r > 32767) || (r < -32768);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (in_ready[0] && in_ready[1] && in_ready[2]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("idle_timeout", 0, 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic s);
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    bit           seen [NI];
    bit           clr  [NI];
    int           c;
    model(a, b, cin, s, es, eco, eov);
    wait_idle();
    input1   = a;
    input2   = b;
    carry_in = cin;
    sub      = s;
    in_valid = 1'b1;
    for (int i = 0; i < NI; i++) begin
      seen[i] = 1'b0;
      clr[i]  = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    input1   = W'($urandom);
    input2   = W'($urandom);
    carry_in = 1'($urandom);
    sub      = 1'($urandom);
    c = 0;
    while (c < 40 && !(clr[0] && clr[1] && clr[2])) begin
      @(posedge clk); #1;
      c++;
      for (int i = 0; i < NI; i++) begin
        if (seen[i] && out_ready[i]) begin
          out_ready[i] = 1'b0;
          clr[i]       = 1'b1;
          chk("ready_after_handshake", i, 32'(in_ready[i]), 1);
        end else if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1;
          chk("latency", i, c, W / CH[i] + 1);
          chk("sum", i, 32'(sum[i]), 32'(es));
          chk("carry_out", i, 32'(carry_out[i]), 32'(eco));
          chk("overflow", i, 32'(overflow[i]), 32'(eov));
          out_ready[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NI; i++)
      if (!clr[i]) chk("result_timeout", i, 0, 1);
  endtask

  vec_t vt [6];

  initial begin
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    bit           ok;

    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst      = 1'b1;
    in_valid = 1'b0;
    input1   = '0;
    input2   = '0;
    carry_in = 1'b0;
    sub      = 1'b0;
    for (int i = 0; i < NI; i++) out_ready[i] = 1'b0;

    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", i, 32'(out_valid[i]), 0);
      chk("rst_sum", i, 32'(sum[i]), 0);
      chk("rst_flags", i, {30'd0, carry_out[i], overflow[i]}, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++)
      chk("post_rst_in_ready", i, 32'(in_ready[i]), 1);

    // Directed vectors: model must agree with the table, then DUT with model
    foreach (vt[j]) begin
      model(vt[j].a, vt[j].b, vt[j].cin, vt[j].sb, es, eco, eov);
      chk("model_table", 0, {15'd0, eco, eov, es},
          {15'd0, vt[j].eco, vt[j].eov, vt[j].es});
      run_op(vt[j].a, vt[j].b, vt[j].cin, vt[j].sb);
    end

    for (int r = 0; r < 40; r++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

    // Consumer stall: result must hold while out_ready stays low
    model(16'h1234, 16'h4321, 1'b1, 1'b0, es, eco, eov);
    wait_idle();
    input1   = 16'h1234;
    input2   = 16'h4321;
    carry_in = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] && out_valid[1] && out_valid[2]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("stall_timeout", 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        chk("stall_valid", i, 32'(out_valid[i]), 1);
        chk("stall_in_ready", i, 32'(in_ready[i]), 0);
        chk("stall_sum", i, 32'(sum[i]), 32'(es));
        chk("stall_flags", i, {30'd0, carry_out[i], overflow[i]},
            {30'd0, eco, eov});
      end
    end
    for (int i = 0; i < NI; i++) out_ready[i] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      out_ready[i] = 1'b0;
      chk("stall_release", i, 32'(in_ready[i]), 1);
    end
    run_op(16'h0102, 16'h0304, 1'b0, 1'b0);

    // Reset sampled on the second CALC edge aborts the operation
    wait_idle();
    input1   = 16'h1111;
    input2   = 16'h2222;
    carry_in = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk("abort_in_ready", i, 32'(in_ready[i]), 1);
      chk("abort_out_valid", i, 32'(out_valid[i]), 0);
      chk("abort_sum", i, 32'(sum[i]), 0);
    end
    run_op(16'd3, 16'd4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
